// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : imem_load_ctrl
//  Purpose  : Arbitrates the instruction-memory port between a program loader
//             and IF fetch, holding the core in reset until a program is ready.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_load_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [31:0]           ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    input  logic                  run_go,
    input  logic                  hazard_freeze,
    input  logic [31:0]           if_pc,
    output logic                  if_freeze,
    output logic                  if_rst,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   ld_count,
    output logic                  ld_overflow
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;
    localparam logic [1:0] c_RUN   = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;

    logic w_in_load;
    logic w_in_run;
    logic w_xfer;
    logic w_unused_pc;

    assign w_in_load = (r_state == c_LOAD);
    assign w_in_run  = (r_state == c_RUN);
    assign w_xfer    = w_in_load & ld_valid;

    // Write strobe is same-cycle so a word lands in memory as it is accepted.
    assign ld_ready    = w_in_load;
    assign mem_we      = w_xfer;
    assign mem_wdata   = w_in_load ? ld_data : 32'd0;
    assign mem_addr    = w_in_run ? if_pc[ADDR_WIDTH+1:2] : r_ptr;
    assign if_rst      = ~w_in_run;
    assign if_freeze   = w_in_run ? hazard_freeze : 1'b1;
    assign busy        = ~w_in_run;
    assign ld_count    = r_count;
    assign ld_overflow = r_overflow;

    // Byte offset and high PC bits have no meaning for word-addressed fetch.
    assign w_unused_pc = ^{if_pc[31:ADDR_WIDTH+2], if_pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_ptr      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (ld_start) begin
                        r_state    <= c_LOAD;
                        r_ptr      <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end else if (run_go) begin
                        r_state <= c_FLUSH;
                    end
                end
                c_LOAD: begin
                    if (w_xfer) begin
                        // DEPTH is a power of two, so the pointer wraps to 0 on its own.
                        r_ptr <= r_ptr + 1'b1;
                        if (r_count != c_DEPTH_CNT) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (ld_last) begin
                            r_state <= c_FLUSH;
                        end else if (r_ptr == c_LAST_ADDR) begin
                            r_overflow <= 1'b1;
                            r_state    <= c_FLUSH;
                        end
                    end
                end
                c_FLUSH: begin
                    r_state <= c_RUN;
                end
                c_RUN: begin
                    if (ld_start) begin
                        r_state    <= c_LOAD;
                        r_ptr      <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Owns the instruction memory port shared by the IF stage and a program loader. After reset it holds the core in reset and frozen. It accepts a program stream over a valid/ready handshake and writes it to instruction memory from word 0. It then hands the memory to IF fetch and releases the core, re-entering load on request at any time.

Parameters:
ADDR_WIDTH, 11, instruction memory word-address width
DEPTH, 2048, memory depth in 32-bit words; must equal 2**ADDR_WIDTH

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
ld_start  in  1  begin (re)load; sampled in IDLE and RUN
ld_valid  in  1  loader word valid
ld_data  in  32  loader instruction word
ld_last  in  1  qualifies final word of program (with ld_valid)
ld_ready  out  1  controller accepts word this cycle
run_go  in  1  in IDLE: release core without loading (memory keeps old contents)
hazard_freeze  in  1  freeze request from hazard logic, forwarded in RUN
if_pc  in  32  IF stage PC (byte address)
if_freeze  out  1  freeze to IF stage PC register
if_rst  out  1  reset to IF/pipeline (PC to 0)
mem_we  out  1  instruction memory write enable
mem_addr  out  ADDR_WIDTH  instruction memory word address
mem_wdata  out  32  instruction memory write data
busy  out  1  high in any state other than RUN
ld_count  out  ADDR_WIDTH+1  words written in current/last load
ld_overflow  out  1  sticky: program exceeded DEPTH words

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst; it applies only on a rising edge of clk.
- States: IDLE, LOAD, FLUSH, RUN. Reset -> IDLE.
- Reset values: ld_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rst=1, if_freeze=1, busy=1, ld_count=0, ld_overflow=0, write pointer=0.
- IDLE: if_rst=1, if_freeze=1, ld_ready=0. If ld_start=1, go to LOAD, with ptr, ld_count and ld_overflow cleared. Else if run_go=1, go to FLUSH. ld_start has priority over run_go. ld_valid is ignored in IDLE.
- LOAD: ld_ready=1 (combinational from state), if_rst=1, if_freeze=1.
  - Transfer when ld_valid & ld_ready. In the same cycle: mem_we=1, mem_addr=ptr, mem_wdata=ld_data.
  - On transfer, ptr and ld_count increment at the edge. Write latency is 0 cycles (same-cycle combinational strobe).
  - If ld_valid=0, then mem_we=0.
  - Transfer with ld_last=1: go to FLUSH.
  - Transfer at ptr==DEPTH-1 with ld_last=0: the word is written, ld_overflow is set, and the state goes to FLUSH. ptr wraps to 0 and is never used beyond DEPTH-1. ld_count saturates at DEPTH.
  - ld_start in LOAD is ignored.
- FLUSH: exactly 1 cycle. if_rst=1, if_freeze=1, mem_we=0, ld_ready=0. Always goes to RUN. This guarantees the PC restarts at 0 after the memory contents are final.
- RUN: if_rst=0, if_freeze=hazard_freeze, busy=0, mem_we=0, mem_addr=if_pc[ADDR_WIDTH+1:2]. if_pc bits above and below that field are ignored; no alignment check.
  - ld_start=1: go to LOAD next cycle, with ptr, ld_count and ld_overflow cleared. During that ld_start cycle, outputs are still RUN values.
- mem_addr mux: ptr in IDLE/LOAD/FLUSH; if_pc field in RUN.
- ld_count and ld_overflow hold their values through FLUSH and RUN until the next ld_start.
- rst asserted in any state, including mid-LOAD: next cycle is IDLE with reset values. The partially loaded memory is not cleared.
- hazard_freeze has no effect outside RUN.

Test Plan:
- Reset, then ld_start, then stream words 0x11111111, 0x22222222, 0x33333333 (last on third) with valid every cycle -> mem_we high 3 cycles at addr 0,1,2 with matching data; ld_count=3; 1 FLUSH cycle (if_rst=1); then RUN with if_rst=0, busy=0.
- In LOAD, toggle ld_valid 1,0,1,0 -> writes only on valid cycles; addresses consecutive 0,1; no write when valid=0.
- RUN with if_pc=0x00000010, then 0x00001FFC -> mem_addr=4, then 2047. hazard_freeze=1 -> if_freeze=1 same cycle. In IDLE, hazard_freeze=0 -> if_freeze stays 1.
- DEPTH=4 build: send 4 words, none with last -> writes at addr 0..3; ld_overflow=1; ld_count=4; FLUSH then RUN.
- Assert rst after 2 words of a load -> next cycle IDLE, ld_count=0, ld_ready=0, if_rst=1. Then run_go=1 -> FLUSH then RUN.
- In RUN, assert ld_start -> next cycle LOAD, if_rst=1, ld_overflow cleared. A new 1-word load with ld_last writes at addr 0. Same-cycle ld_start and run_go in IDLE -> LOAD.
